// File: rtl/rv_pkg.sv
// Shared RV32I definitions for the fetch/decode slice: base opcodes and
// sequencer states.
package rv_pkg;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {
        FETCH    = 2'd0,
        MEM_WAIT = 2'd1,
        DECODE   = 2'd2
    } state_t;

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: rebuilds the sign-extended RV32I immediate for the
// instruction format implied by the opcode. Purely combinational.
module imm_gen
    import rv_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm
);

    always_comb begin
        imm = '0;
        case (instr[6:0])
            OP_IMM, LOAD, JALR, SYSTEM:
                imm = {{20{instr[31]}}, instr[31:20]};
            STORE:
                imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            BRANCH:
                imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            LUI, AUIPC:
                imm = {instr[31:12], 12'b0};
            JAL:
                imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:
                imm = '0;
        endcase
    end

endmodule

// File: rtl/fetch_decode_ctrl.sv
// Fetch/decode sequencer: presents pc to a 1-cycle synchronous instruction
// memory, latches the returned word and exposes its decoded fields.
module fetch_decode_ctrl
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] read_data,
    output logic [31:0] read_address,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [6:0]  opcode,
    output logic [4:0]  rd,
    output logic [2:0]  funct3,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [6:0]  funct7,
    output logic [31:0] imm
);

    state_t      state;
    logic [31:0] next_pc;

    assign read_address = pc;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

    imm_gen u_imm_gen (
        .instr (instr),
        .imm   (imm)
    );

    // Only JAL redirects; branches and JALR need register values this block lacks.
    always_comb begin
        next_pc = pc + 32'd4;
        if (opcode == JAL) begin
            next_pc = pc + imm;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            instr       <= '0;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    state       <= MEM_WAIT;
                    instr_valid <= 1'b0;
                end
                MEM_WAIT: begin
                    instr       <= read_data;
                    instr_valid <= 1'b1;
                    state       <= DECODE;
                end
                DECODE: begin
                    pc          <= next_pc;
                    instr_valid <= 1'b0;
                    state       <= FETCH;
                end
                default: begin
                    state       <= FETCH;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// Scoreboard bench for fetch_decode_ctrl: two instances (default and wrapping
// RESET_PC), each fed by a 16-word synchronous memory model.
module tb_fetch_decode_ctrl;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  funct7;
        logic [31:0] imm;
        logic [31:0] next_pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, rst_n2;
    logic [31:0] read_data, read_data2;
    logic [31:0] read_address, pc, instr, imm;
    logic [31:0] read_address2, pc2, instr2, imm2;
    logic        instr_valid, instr_valid2;
    logic [6:0]  opcode, funct7, opcode2, funct7_2;
    logic [4:0]  rd, rs1, rs2, rd2, rs1_2, rs2_2;
    logic [2:0]  funct3, funct3_2;

    logic [31:0] mem  [16];
    logic [31:0] mem2 [16];

    exp_t sb  [$];
    exp_t sb2 [$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        read_data  <= mem[read_address[5:2]];
        read_data2 <= mem2[read_address2[5:2]];
    end

    fetch_decode_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .read_data    (read_data),
        .read_address (read_address),
        .pc           (pc),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .opcode       (opcode),
        .rd           (rd),
        .funct3       (funct3),
        .rs1          (rs1),
        .rs2          (rs2),
        .funct7       (funct7),
        .imm          (imm)
    );

    fetch_decode_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk          (clk),
        .rst_n        (rst_n2),
        .read_data    (read_data2),
        .read_address (read_address2),
        .pc           (pc2),
        .instr        (instr2),
        .instr_valid  (instr_valid2),
        .opcode       (opcode2),
        .rd           (rd2),
        .funct3       (funct3_2),
        .rs1          (rs1_2),
        .rs2          (rs2_2),
        .funct7       (funct7_2),
        .imm          (imm2)
    );

    task automatic test_reset();
        exp_t e;
        sb.push_back('{32'h0, 32'h00500093, 7'h13, 5'd1, 3'd0, 5'd0, 5'd5, 7'h00, 32'd5, 32'd4});
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks += 5;
        if (read_address !== 32'h0) begin errors++; $display("FAIL reset_read_address: got %h expected %h", read_address, 32'h0); end
        if (instr_valid !== 1'b0)   begin errors++; $display("FAIL reset_instr_valid: got %b expected 0", instr_valid); end
        if (imm !== 32'h0)          begin errors++; $display("FAIL reset_imm: got %h expected 0", imm); end
        if (instr !== 32'h0)        begin errors++; $display("FAIL reset_instr: got %h expected 0", instr); end
        if (opcode !== 7'h0)        begin errors++; $display("FAIL reset_opcode: got %h expected 0", opcode); end
        rst_n = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            checks++;
            if (instr_valid !== (c == 3)) begin
                errors++;
                $display("FAIL reset_first_valid_cycle%0d: got %b expected %b", c, instr_valid, (c == 3));
            end
        end
        e = sb.pop_front();
        checks += 6;
        if (pc !== e.pc)         begin errors++; $display("FAIL addi_pc: got %h expected %h", pc, e.pc); end
        if (opcode !== e.opcode) begin errors++; $display("FAIL addi_opcode: got %h expected %h", opcode, e.opcode); end
        if (rd !== e.rd)         begin errors++; $display("FAIL addi_rd: got %0d expected %0d", rd, e.rd); end
        if (rs1 !== e.rs1)       begin errors++; $display("FAIL addi_rs1: got %0d expected %0d", rs1, e.rs1); end
        if (funct3 !== e.funct3) begin errors++; $display("FAIL addi_funct3: got %0d expected %0d", funct3, e.funct3); end
        if (imm !== e.imm)       begin errors++; $display("FAIL addi_imm: got %h expected %h", imm, e.imm); end
        @(posedge clk); #1;
        checks++;
        if (read_address !== e.next_pc) begin errors++; $display("FAIL addi_next_addr: got %h expected %h", read_address, e.next_pc); end
    endtask

    task automatic test_program();
        exp_t e;
        bit   found;
        sb.push_back('{32'd4,  32'h008000EF, 7'h6F, 5'd1,  3'd0, 5'd0,  5'd8,  7'h00, 32'd8,         32'd12});
        sb.push_back('{32'd12, 32'hFFDFF06F, 7'h6F, 5'd0,  3'd7, 5'd31, 5'd29, 7'h7F, 32'hFFFF_FFFC, 32'd8});
        sb.push_back('{32'd8,  32'h0020A423, 7'h23, 5'd8,  3'd2, 5'd1,  5'd2,  7'h00, 32'd8,         32'd12});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            found = 1'b0;
            for (int i = 0; i < 8 && !found; i++) begin
                @(negedge clk);
                if (instr_valid === 1'b1) found = 1'b1;
            end
            checks++;
            if (!found) begin
                errors++;
                $display("FAIL prog_timeout_pc%0h: got no instr_valid expected pulse", e.pc);
                continue;
            end
            checks += 10;
            if (pc !== e.pc)         begin errors++; $display("FAIL prog_pc: got %h expected %h", pc, e.pc); end
            if (instr !== e.instr)   begin errors++; $display("FAIL prog_instr@%0h: got %h expected %h", e.pc, instr, e.instr); end
            if (opcode !== e.opcode) begin errors++; $display("FAIL prog_opcode@%0h: got %h expected %h", e.pc, opcode, e.opcode); end
            if (rd !== e.rd)         begin errors++; $display("FAIL prog_rd@%0h: got %0d expected %0d", e.pc, rd, e.rd); end
            if (funct3 !== e.funct3) begin errors++; $display("FAIL prog_funct3@%0h: got %0d expected %0d", e.pc, funct3, e.funct3); end
            if (rs1 !== e.rs1)       begin errors++; $display("FAIL prog_rs1@%0h: got %0d expected %0d", e.pc, rs1, e.rs1); end
            if (rs2 !== e.rs2)       begin errors++; $display("FAIL prog_rs2@%0h: got %0d expected %0d", e.pc, rs2, e.rs2); end
            if (funct7 !== e.funct7) begin errors++; $display("FAIL prog_funct7@%0h: got %h expected %h", e.pc, funct7, e.funct7); end
            if (imm !== e.imm)       begin errors++; $display("FAIL prog_imm@%0h: got %h expected %h", e.pc, imm, e.imm); end
            @(posedge clk); #1;
            if (read_address !== e.next_pc) begin errors++; $display("FAIL prog_next_addr@%0h: got %h expected %h", e.pc, read_address, e.next_pc); end
        end
    endtask

    task automatic test_reset_mid();
        int  cycles;
        bit  found;
        // Entered in FETCH of pc=12; one more edge reaches MEM_WAIT.
        @(posedge clk); #1;
        checks += 2;
        if (read_address !== 32'd12) begin errors++; $display("FAIL mid_addr_before: got %h expected %h", read_address, 32'd12); end
        if (instr_valid !== 1'b0)    begin errors++; $display("FAIL mid_valid_before: got %b expected 0", instr_valid); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks += 3;
        if (pc !== 32'h0)         begin errors++; $display("FAIL mid_pc: got %h expected 0", pc); end
        if (instr !== 32'h0)      begin errors++; $display("FAIL mid_instr: got %h expected 0", instr); end
        if (instr_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b expected 0", instr_valid); end
        rst_n = 1'b1;
        found  = 1'b0;
        cycles = 0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge clk);
            cycles++;
            if (instr_valid === 1'b1) found = 1'b1;
        end
        checks += 3;
        if (!found || cycles != 3) begin errors++; $display("FAIL mid_restart_latency: got %0d cycles expected 3", cycles); end
        if (pc !== 32'h0)          begin errors++; $display("FAIL mid_restart_pc: got %h expected 0", pc); end
        if (instr !== 32'h00500093) begin errors++; $display("FAIL mid_restart_instr: got %h expected %h", instr, 32'h00500093); end
    endtask

    task automatic test_wrap();
        exp_t e;
        bit   found;
        sb2.push_back('{32'hFFFF_FFFC, 32'h00000013, 7'h13, 5'd0,  3'd0, 5'd0, 5'd0, 7'h00, 32'h0,         32'd0});
        sb2.push_back('{32'd0,         32'hABCDE2B7, 7'h37, 5'd5,  3'd6, 5'd0, 5'd0, 7'h00, 32'hABCD_E000, 32'd4});
        sb2.push_back('{32'd4,         32'hFE208CE3, 7'h63, 5'd25, 3'd0, 5'd0, 5'd0, 7'h00, 32'hFFFF_FFF8, 32'd8});
        sb2.push_back('{32'd8,         32'hFE312A23, 7'h23, 5'd20, 3'd2, 5'd0, 5'd0, 7'h00, 32'hFFFF_FFF4, 32'd12});
        sb2.push_back('{32'd12,        32'h402081B3, 7'h33, 5'd3,  3'd0, 5'd0, 5'd0, 7'h00, 32'h0,         32'd16});
        sb2.push_back('{32'd16,        32'h80000397, 7'h17, 5'd7,  3'd0, 5'd0, 5'd0, 7'h00, 32'h8000_0000, 32'd20});
        checks += 2;
        if (read_address2 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_reset_addr: got %h expected %h", read_address2, 32'hFFFF_FFFC); end
        if (instr_valid2 !== 1'b0)           begin errors++; $display("FAIL wrap_reset_valid: got %b expected 0", instr_valid2); end
        rst_n2 = 1'b1;
        while (sb2.size() > 0) begin
            e = sb2.pop_front();
            found = 1'b0;
            for (int i = 0; i < 8 && !found; i++) begin
                @(negedge clk);
                if (instr_valid2 === 1'b1) found = 1'b1;
            end
            checks++;
            if (!found) begin
                errors++;
                $display("FAIL imm_timeout_pc%0h: got no instr_valid expected pulse", e.pc);
                continue;
            end
            checks += 6;
            if (pc2 !== e.pc)         begin errors++; $display("FAIL imm_pc: got %h expected %h", pc2, e.pc); end
            if (instr2 !== e.instr)   begin errors++; $display("FAIL imm_instr@%0h: got %h expected %h", e.pc, instr2, e.instr); end
            if (opcode2 !== e.opcode) begin errors++; $display("FAIL imm_opcode@%0h: got %h expected %h", e.pc, opcode2, e.opcode); end
            if (rd2 !== e.rd)         begin errors++; $display("FAIL imm_rd@%0h: got %0d expected %0d", e.pc, rd2, e.rd); end
            if (imm2 !== e.imm)       begin errors++; $display("FAIL imm_value@%0h: got %h expected %h", e.pc, imm2, e.imm); end
            @(posedge clk); #1;
            if (read_address2 !== e.next_pc) begin errors++; $display("FAIL imm_next_addr@%0h: got %h expected %h", e.pc, read_address2, e.next_pc); end
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        rst_n2 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            mem[i]  = 32'h0;
            mem2[i] = 32'h0;
        end
        mem[0]  = 32'h00500093;
        mem[1]  = 32'h008000EF;
        mem[2]  = 32'h0020A423;
        mem[3]  = 32'hFFDFF06F;
        mem2[15] = 32'h00000013;
        mem2[0]  = 32'hABCDE2B7;
        mem2[1]  = 32'hFE208CE3;
        mem2[2]  = 32'hFE312A23;
        mem2[3]  = 32'h402081B3;
        mem2[4]  = 32'h80000397;

        test_reset();
        test_program();
        test_reset_mid();
        test_wrap();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
